uart_rx: RTL and testbench

- UART 16550-style serial receiver; counterpart of the core's transmit block.
- Recovers 5–8 data bits, optional parity and stop from the serial input using 16x oversampling.
- Presents the received character in a receive buffer (RBR) with line-status flags (data ready, parity/framing/overrun error, break) to the register-file / bus-interface logic.
- Frame format comes from the shared LCR register.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 27 ++
 rtl/uart_rx.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receive and transmit blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: receiver state enum, LCR field bit indices, word-length decode.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // LCR field positions: word-length select is the 2-bit field starting at LCR_WLS.
  localparam int LCR_WLS = 0;
  localparam int LCR_PEN = 3;
  localparam int LCR_EPS = 4;

  // 2-bit word-length select to character length in bits (5..8).
  function automatic logic [3:0] word_len(input logic [1:0] wls);
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: multi-flop synchronizer for an asynchronous idle-high input.
// Latency: SYNC_STAGES clk from din to dout.
// Backpressure: none.
// Ports: clk, rst (sync, active-high, flops reset to 1), din (async), dout (synchronized).
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2  // >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Reset to 1 so an idle-high line never looks like a start edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16550-style serial receiver, oversampled, 5-8 data bits, optional parity, one stop bit.
// Latency: rx_done, data_ready, rbr_data and error flags update on the clk edge of the stop-bit sampling tick.
// Backpressure: none; a frame completing while RBR is unread (and not being read) is dropped and sets overrun_err.
// Ports: clk, rst (sync active-high), baud_tick (OVERSAMPLE x bit rate), srx (async serial in),
//        lcr (frame format), read_rbr / read_lsr (bus read strobes), rbr_data, data_ready,
//        parity_err / framing_err / overrun_err / break_int (sticky), rx_done (pulse), rx_busy.
// Optional build macro: UART_RX_MAJORITY_EN selects a 2-of-3 vote around each bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,  // even, 8..16 (tick counter is 4 bits wide)
  parameter int SYNC_STAGES = 2    // >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       srx,
  input  logic [7:0] lcr,
  input  logic       read_rbr,
  input  logic       read_lsr,
  output logic [7:0] rbr_data,
  output logic       data_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       break_int,
  output logic       rx_done,
  output logic       rx_busy
);

  localparam logic [3:0] BIT_DEC = 4'(OVERSAMPLE - 1);

  logic s;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (srx),
    .dout (s)
  );

  // bit_val is the line value decided at the current tick.
  logic bit_val;

`ifdef UART_RX_MAJORITY_EN
  // Decisions move one tick later (centre+1) so the two previous ticks (centre-1,
  // centre) are already captured. Data/stop decisions stay OVERSAMPLE ticks apart,
  // so relative to each bit they also land at centre+1.
  localparam logic [3:0] START_DEC = 4'(OVERSAMPLE / 2);

  logic [1:0] vote_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vote_q <= 2'b11;
    end else if (baud_tick) begin
      vote_q <= {vote_q[0], s};
    end
  end

  assign bit_val = (vote_q[1] & vote_q[0]) | (vote_q[1] & s) | (vote_q[0] & s);
`else
  localparam logic [3:0] START_DEC = 4'(OVERSAMPLE / 2 - 1);

  assign bit_val = s;
`endif

  rx_state_e  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic       armed_q, armed_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] wls_q, wls_d;
  logic       pen_q, pen_d;
  logic       eps_q, eps_d;
  logic       par_q, par_d;
  logic       frame_end;
  logic [3:0] wlen;

  // Only the frame-format fields of LCR are used here.
  logic unused_lcr;
  assign unused_lcr = ^{lcr[7:5], lcr[2]};

  assign wlen = word_len(wls_q);

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    armed_d   = armed_q;
    shift_d   = shift_q;
    wls_d     = wls_q;
    pen_d     = pen_q;
    eps_d     = eps_q;
    par_d     = par_q;
    frame_end = 1'b0;

    case (state_q)
      RX_IDLE: begin
        // Requiring a high level before each start keeps a held-low line to one character.
        if (s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = RX_START;
          tick_d  = 4'd0;
          shift_d = 8'd0;
          wls_d   = lcr[LCR_WLS +: 2];
          pen_d   = lcr[LCR_PEN];
          eps_d   = lcr[LCR_EPS];
        end
      end

      RX_START: begin
        if (baud_tick) begin
          if (tick_q == START_DEC) begin
            if (!bit_val) begin
              state_d = RX_DATA;
              tick_d  = 4'd0;
              bit_d   = 3'd0;
            end else begin
              state_d = RX_IDLE;  // false start, stays armed
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      RX_DATA: begin
        if (baud_tick) begin
          if (tick_q == BIT_DEC) begin
            tick_d         = 4'd0;
            shift_d[bit_q] = bit_val;
            if ({1'b0, bit_q} == wlen - 4'd1) begin
              state_d = pen_q ? RX_PARITY : RX_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      RX_PARITY: begin
        if (baud_tick) begin
          if (tick_q == BIT_DEC) begin
            tick_d  = 4'd0;
            par_d   = bit_val;
            state_d = RX_STOP;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      RX_STOP: begin
        if (baud_tick) begin
          if (tick_q == BIT_DEC) begin
            tick_d    = 4'd0;
            frame_end = 1'b1;
            armed_d   = 1'b0;
            state_d   = RX_IDLE;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Frame-end evaluation; bit_val is the stop sample when frame_end is high.
  // Bits above the word length are zero (cleared at start), so ^shift_q covers data only.
  logic pe_calc, parity_hit, brk_hit, load_rbr;

  assign pe_calc    = eps_q ? (^shift_q ^ par_q) : ~(^shift_q ^ par_q);
  assign parity_hit = pen_q & pe_calc;
  assign brk_hit    = (shift_q == 8'd0) & (~pen_q | ~par_q) & ~bit_val;
  assign load_rbr   = ~data_ready | read_rbr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= 4'd0;
      bit_q       <= 3'd0;
      armed_q     <= 1'b0;
      shift_q     <= 8'd0;
      wls_q       <= 2'd0;
      pen_q       <= 1'b0;
      eps_q       <= 1'b0;
      par_q       <= 1'b0;
      rbr_data    <= 8'd0;
      data_ready  <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      break_int   <= 1'b0;
      rx_done     <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      armed_q <= armed_d;
      shift_q <= shift_d;
      wls_q   <= wls_d;
      pen_q   <= pen_d;
      eps_q   <= eps_d;
      par_q   <= par_d;
      rx_done <= frame_end;

      // Clears first; a same-cycle load or error set below takes priority.
      if (read_rbr) begin
        data_ready <= 1'b0;
      end
      if (read_lsr) begin
        parity_err  <= 1'b0;
        framing_err <= 1'b0;
        overrun_err <= 1'b0;
        break_int   <= 1'b0;
      end

      if (frame_end) begin
        if (load_rbr) begin
          rbr_data   <= shift_q;
          data_ready <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
        if (!bit_val) begin
          framing_err <= 1'b1;
        end
        if (parity_hit) begin
          parity_err <= 1'b1;
        end
        if (brk_hit) begin
          break_int <= 1'b1;
        end
      end
    end
  end

  assign rx_busy = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a frame-level reference model of the receiver.
// Latency: n/a (testbench).
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       srx;
  logic [7:0] lcr;
  logic       read_rbr;
  logic       read_lsr;
  logic [7:0] rbr_data;
  logic       data_ready, parity_err, framing_err, overrun_err, break_int, rx_done, rx_busy;

  always #5 clk = ~clk;

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .srx         (srx),
    .lcr         (lcr),
    .read_rbr    (read_rbr),
    .read_lsr    (read_lsr),
    .rbr_data    (rbr_data),
    .data_ready  (data_ready),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .break_int   (break_int),
    .rx_done     (rx_done),
    .rx_busy     (rx_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tick_div = 3;
  int div_cnt  = 0;
  int done_cnt = 0;

  // Reference register state
  logic [7:0] m_rbr;
  bit m_dr, m_pe, m_fe, m_oe, m_bi;

  // Baud tick generator: one tick every tick_div clocks; tick_div==1 holds it high.
  always @(posedge clk) begin
    #1;
    if (tick_div <= 1) begin
      baud_tick = 1'b1;
    end else if (div_cnt >= tick_div - 1) begin
      div_cnt   = 0;
      baud_tick = 1'b1;
    end else begin
      div_cnt   = div_cnt + 1;
      baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done === 1'b1) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rbr"}, rbr_data, m_rbr);
    chk({tag, ".dr"},  data_ready, m_dr);
    chk({tag, ".pe"},  parity_err, m_pe);
    chk({tag, ".fe"},  framing_err, m_fe);
    chk({tag, ".oe"},  overrun_err, m_oe);
    chk({tag, ".bi"},  break_int, m_bi);
  endtask

  task automatic model_reset();
    m_rbr = 8'd0; m_dr = 0; m_pe = 0; m_fe = 0; m_oe = 0; m_bi = 0;
  endtask

  // Frame-level expectations from the line contents.
  task automatic model_frame(input logic [7:0] d, input bit pen, input bit eps,
                             input bit par, input bit stopv, input bit rd);
    int ones;
    bit perr, brk;
    ones = $countones(d) + (pen ? int'(par) : 0);
    perr = pen && (eps ? (ones % 2 != 0) : (ones % 2 == 0));
    brk  = (d == 8'd0) && (!pen || !par) && !stopv;
    if (!m_dr || rd) begin
      m_rbr = d;
      m_dr  = 1;
    end else begin
      m_oe = 1;
    end
    if (!stopv) m_fe = 1;
    if (perr)   m_pe = 1;
    if (brk)    m_bi = 1;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    srx = v;
    wait_clks(OS * tick_div);
  endtask

  // Start, data LSB first, optional parity, stop, then two idle bit times.
  // lcr is scrambled after the start bit: the receiver must keep the latched format.
  task automatic send_frame(input logic [7:0] d, input int wl, input bit pen,
                            input bit par, input bit stopv);
    send_bit(1'b0);
    lcr = 8'($urandom);
    for (int i = 0; i < wl; i++) send_bit(d[i]);
    if (pen) send_bit(par);
    send_bit(stopv);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  // Assert read_rbr for exactly the clock on which the stop bit is sampled:
  // the n_ticks-th baud tick after the receiver leaves idle.
  task automatic read_at_done(input int n_ticks);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (rx_busy === 1'b1) seen = 1;
    end
    if (!seen) begin
      chk("rd_done.busy", rx_busy, 1);
    end else begin
      for (int i = 0; i < 20000 && cnt < n_ticks; i++) begin
        if (baud_tick === 1'b1) cnt = cnt + 1;
        if (cnt == n_ticks) begin
          read_rbr = 1'b1;
          @(posedge clk);
          #1;
          read_rbr = 1'b0;
        end else begin
          @(posedge clk);
          #2;
        end
      end
      if (cnt != n_ticks) chk("rd_done.ticks", cnt, n_ticks);
    end
  endtask

  task automatic rx_frame(input string tag, input logic [7:0] data, input logic [7:0] lcr_v,
                          input bit bad_par, input bit stopv, input bit rd);
    int wl, d0;
    bit pen, eps, par;
    logic [7:0] d, mask;
    wl   = 5 + int'(lcr_v[1:0]);
    pen  = lcr_v[3];
    eps  = lcr_v[4];
    mask = 8'((1 << wl) - 1);
    d    = data & mask;
    par  = eps ? ^d : ~^d;
    if (bad_par) par = ~par;
    lcr  = lcr_v;
    d0   = done_cnt;
    if (rd) begin
      fork
        send_frame(d, wl, pen, par, stopv);
        read_at_done(OS / 2 + OS * (wl + int'(pen) + 1));
      join
    end else begin
      send_frame(d, wl, pen, par, stopv);
    end
    model_frame(d, pen, eps, par, stopv, rd);
    chk({tag, ".done"}, done_cnt - d0, 1);
    check_all(tag);
  endtask

  task automatic do_read_rbr();
    read_rbr = 1'b1;
    wait_clks(1);
    read_rbr = 1'b0;
    m_dr = 0;
  endtask

  task automatic do_read_lsr();
    read_lsr = 1'b1;
    wait_clks(1);
    read_lsr = 1'b0;
    m_pe = 0; m_fe = 0; m_oe = 0; m_bi = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1; srx = 1'b1; lcr = 8'h03; read_rbr = 1'b0; read_lsr = 1'b0; baud_tick = 1'b0;
    model_reset();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_clks(2);
    check_all("reset");
    chk("reset.rx_done", rx_done, 0);
    chk("reset.rx_busy", rx_busy, 0);
    wait_clks(OS * tick_div);

    // 8N1
    rx_frame("8n1", 8'hA5, 8'h03, 0, 1, 0);
    do_read_rbr();
    check_all("8n1.read");

    // 7E1 with wrong parity
    rx_frame("7e1", 8'h55, 8'h1A, 1, 1, 0);
    do_read_lsr();
    check_all("7e1.lsr");
    do_read_rbr();

    // 5N1 with stop bit low
    rx_frame("5n1", 8'h1F, 8'h00, 0, 0, 0);
    do_read_rbr();
    do_read_lsr();

    // Break: line low for three 8N1 frame times
    lcr = 8'h03;
    d0  = done_cnt;
    srx = 1'b0;
    wait_clks(3 * 10 * OS * tick_div);
    chk("break.busy_held_low", rx_busy, 0);
    srx = 1'b1;
    wait_clks(2 * OS * tick_div);
    model_frame(8'h00, 0, 0, 0, 0, 0);
    chk("break.done", done_cnt - d0, 1);
    check_all("break");
    do_read_rbr();
    do_read_lsr();

    // Overrun, then a load racing a read on the completion clock
    rx_frame("ovr.a", 8'h11, 8'h03, 0, 1, 0);
    rx_frame("ovr.b", 8'h22, 8'h03, 0, 1, 0);
    do_read_lsr();
    rx_frame("ovr.rd", 8'h22, 8'h03, 0, 1, 1);
    do_read_rbr();

    // Glitch: 4 ticks low is a false start
    d0  = done_cnt;
    srx = 1'b0;
    wait_clks(4 * tick_div);
    chk("glitch.busy_hi", rx_busy, 1);
    srx = 1'b1;
    wait_clks(OS * tick_div);
    chk("glitch.busy_lo", rx_busy, 0);
    chk("glitch.done", done_cnt - d0, 0);
    check_all("glitch");

    // Reset in the middle of DATA after leaving a character unread
    rx_frame("pre_rst", 8'h5A, 8'h03, 1, 0, 0);
    lcr = 8'h03;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_clks(OS * tick_div / 2);
    d0  = done_cnt;
    rst = 1'b1;
    wait_clks(2);
    model_reset();
    check_all("midrst");
    chk("midrst.busy", rx_busy, 0);
    srx = 1'b1;
    rst = 1'b0;
    wait_clks(2 * OS * tick_div);
    chk("midrst.done", done_cnt - d0, 0);
    chk("midrst.busy_after", rx_busy, 0);
    rx_frame("post_rst", 8'h3C, 8'h03, 0, 1, 0);

    // Randomized frames, formats, error injections, reads, tick rates
    for (int n = 0; n < 24; n++) begin
      int mode;
      logic [7:0] lcr_v, data;
      bit bad, stopv;
      tick_div = int'($urandom_range(1, 3));
      lcr_v    = 8'($urandom);
      data     = 8'($urandom);
      bad      = ($urandom_range(0, 4) == 0);
      stopv    = ($urandom_range(0, 7) != 0);
      mode     = int'($urandom_range(0, 3));
      rx_frame("rnd", data, lcr_v, bad, stopv, mode == 3);
      if (mode == 1) do_read_rbr();
      if (mode == 2) do_read_lsr();
      if (mode != 0) check_all("rnd.after_read");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
